// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit placed beside the EX-stage ALU.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock on operand
// magnitudes, with sign correction applied as the result is written on entry to DONE.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous reset, active-low
//   start_i   request, sampled only in IDLE
//   funct3_i  M-extension funct3 (000 MUL .. 111 REMU)
//   op_a_i    rs1 (multiplicand / dividend)
//   op_b_i    rs2 (multiplier / divisor)
//   flush_i   abort the current operation
//   stall_o   pipeline stall request (combinational)
//   busy_o    state != IDLE
//   done_o    result valid this cycle
//   result_o  registered result, held between operations
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    // Multiply: multiplicand magnitude. Divide: divisor magnitude.
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    // Multiply: {hi,lo} is the running product, lo starts as the multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  result_q, result_d;
    // Value of result_o before the current op wrote it; restored if DONE is flushed.
    logic [WIDTH-1:0]  prev_result_q, prev_result_d;

    // Accept-time decode
    logic              is_div_in, a_signed_in, b_signed_in, sign_a_in, sign_b_in;
    logic [WIDTH-1:0]  a_mag_in, b_mag_in;
    logic              div_zero_in, div_ovf_in;
    logic [WIDTH-1:0]  special_res;

    always_comb begin
        is_div_in   = funct3_i[2];
        a_signed_in = (funct3_i != 3'b011) && (funct3_i != 3'b101) && (funct3_i != 3'b111);
        b_signed_in = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sign_a_in   = a_signed_in & op_a_i[WIDTH-1];
        sign_b_in   = b_signed_in & op_b_i[WIDTH-1];
        a_mag_in    = sign_a_in ? -op_a_i : op_a_i;
        b_mag_in    = sign_b_in ? -op_b_i : op_b_i;
        div_zero_in = is_div_in && (op_b_i == '0);
        div_ovf_in  = ((funct3_i == 3'b100) || (funct3_i == 3'b110)) &&
                      (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_i == '1);
        // funct3_i[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero_in) begin
            special_res = funct3_i[1] ? op_a_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : op_a_i;
        end
    end

    // One iteration of the datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_diff[WIDTH];
        if (funct3_q[2]) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the final iteration's outcome
    logic [2*WIDTH-1:0] prod_u, prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s, fin_res;
    logic               neg_res;

    always_comb begin
        neg_res = sign_a_q ^ sign_b_q;
        prod_u  = {step_hi, step_lo};
        prod_s  = neg_res ? -prod_u : prod_u;
        quot_s  = neg_res ? -step_lo : step_lo;
        rem_s   = sign_a_q ? -step_hi : step_hi;
        unique case (funct3_q)
            3'b000:                 fin_res = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fin_res = quot_s;
            default:                fin_res = rem_s;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        funct3_d      = funct3_q;
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        opnd_d        = opnd_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        result_d      = result_q;
        prev_result_d = prev_result_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    funct3_d = funct3_i;
                    sign_a_d = sign_a_in;
                    sign_b_d = sign_b_in;
                    opnd_d   = is_div_in ? b_mag_in : a_mag_in;
                    hi_d     = '0;
                    lo_d     = is_div_in ? a_mag_in : b_mag_in;
                    count_d  = '0;
                    if (div_zero_in || div_ovf_in) begin
                        prev_result_d = result_q;
                        result_d      = special_res;
                        state_d       = StDone;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    count_d = count_q + CntW'(1);
                    if (count_q == CntW'(WIDTH - 1)) begin
                        prev_result_d = result_q;
                        result_d      = fin_res;
                        state_d       = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (flush_i) begin
                    result_d = prev_result_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            count_q       <= '0;
            funct3_q      <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            opnd_q        <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            result_q      <= '0;
            prev_result_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            funct3_q      <= funct3_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            opnd_q        <= opnd_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            result_q      <= result_d;
            prev_result_q <= prev_result_d;
        end
    end

    // rst_n masks the accept term so stall_o reads 0 while reset is held.
    assign stall_o  = (rst_n && (state_q == StIdle) && start_i && !flush_i) ||
                      (state_q == StBusy) || (state_q == StDone);
    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone) && !flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: hand-computed RV32M results, latencies,
// flush, asynchronous reset and back-to-back behaviour.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .funct3_i (funct3),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .flush_i  (flush),
        .stall_o  (stall),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts in cycle 0 (just after a rising edge); returns just after the edge that
    // follows the first IDLE cycle after DONE.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(negedge clk);
        check_eq({tag, " stall_at_accept"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start  = 1'b0;
        // Changes after accept must not disturb the op in flight.
        op_a   = ~a;
        op_b   = a ^ b;
        funct3 = ~f3;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            #1;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " result"}, result, exp);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq({tag, " busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, " done_once"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        int d1;
        int d2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic seen_done;

        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        #3;
        check_eq("reset result", result, 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset stall", 32'(stall), 32'd0);
        #14;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'h0000_002A, 33);
        do_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 33);
        do_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 33);
        do_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        do_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF, 33);
        do_op("divu_5_0",    3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        do_op("remu_5_0",    3'b111, 32'd5,        32'd0,        32'd5,         1);
        do_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Flush a DIV in cycle 10.
        funct3 = 3'b100;
        op_a   = 32'd100;
        op_b   = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        seen_done = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_busy_c10", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_idle_c11", 32'(busy), 32'd0);
        check_eq("flush_stall_c11", 32'(stall), 32'd0);
        check_eq("flush_result_kept", result, 32'h8000_0000);
        repeat (30) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check_eq("flush_no_done", 32'(seen_done), 32'd0);
        @(posedge clk);
        #1;

        do_op("mul_3x3", 3'b000, 32'd3, 32'd3, 32'd9, 33);

        // Flush while in DONE: pulse masked, result_o keeps the earlier value.
        funct3 = 3'b000;
        op_a   = 32'd5;
        op_b   = 32'd5;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_done_masked", 32'(done), 32'd0);
        check_eq("flush_done_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_done_idle", 32'(busy), 32'd0);
        check_eq("flush_done_result", result, 32'd9);
        @(posedge clk);
        #1;

        // Asynchronous reset in cycle 15 of a MUL.
        funct3 = 3'b000;
        op_a   = 32'd11;
        op_b   = 32'd13;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_result", result, 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_stall", 32'(stall), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_stall_after", 32'(stall), 32'd0);
        check_eq("arst_busy_after", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        do_op("divu_100_7", 3'b101, 32'd100,       32'd7,         32'd14, 33);
        do_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,  33);
        do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,  1);

        // start_i held across DONE: one done per op, second accepted the cycle after DONE.
        funct3 = 3'b000;
        op_a   = 32'd2;
        op_b   = 32'd3;
        start  = 1'b1;
        ndone  = 0;
        d1     = 0;
        d2     = 0;
        r1     = '0;
        r2     = '0;
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = c;
                    r1 = result;
                end else begin
                    d2 = c;
                    r2 = result;
                end
            end
            if (c == 34) begin
                check_eq("b2b_idle_c34", 32'(busy), 32'd0);
                check_eq("b2b_stall_c34", 32'(stall), 32'd1);
            end
            if (c == 35) check_eq("b2b_busy_c35", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            if (c == 33) begin
                op_a = 32'd4;
                op_b = 32'd5;
            end
            if (c == 66) start = 1'b0;
        end
        check_eq("b2b_done_count", 32'(ndone), 32'd2);
        check_eq("b2b_first_cycle", 32'(d1), 32'd33);
        check_eq("b2b_first_result", r1, 32'd6);
        check_eq("b2b_second_cycle", 32'(d2), 32'd67);
        check_eq("b2b_second_result", r2, 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
